mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences the shared block-wide data memory for two requesters: the instruction-fetch
//  path (read-only) and the data path (read/write). Arbitrates, drives the memory's
//  address/readable/writable/write strobes for one cycle, waits a fixed modelled latency,
//  then captures the two returned blocks {out1,out2} and returns them with a ready pulse.
// PARAMETERS
//  ADDR_W   32   byte address width (matches `WORD_SIZE)
//  BLOCK_W  128  memory block width (matches `BLOCK_SIZE); read line = 2*BLOCK_W
//  LATENCY  2    wait cycles between strobe cycle and capture (0 allowed)
// PORTS
//  clk        in   1          clock; all state on posedge
//  rst_n      in   1          reset, asynchronous, active-low
//  i_req      in   1          fetch request; held until i_ready
//  i_addr     in   ADDR_W     fetch address
//  i_ready    out  1          one-cycle completion pulse for fetch
//  i_rdata    out  2*BLOCK_W  fetched line {out1,out2}; valid with i_ready, held after
//  d_req      in   1          data request; held until d_ready
//  d_we       in   1          1 = write block, 0 = read line
//  d_addr     in   ADDR_W     data address
//  d_wdata    in   BLOCK_W    write block
//  d_ready    out  1          one-cycle completion pulse for data (reads and writes)
//  d_rdata    out  2*BLOCK_W  data line {out1,out2}; updated on reads only
//  mem_addr   out  ADDR_W     memory address; stable from ISSUE through RESP
//  mem_rd     out  1          memory readable strobe
//  mem_wr     out  1          memory writable strobe
//  mem_wdata  out  BLOCK_W    memory write block
//  mem_out1   in   BLOCK_W    memory first block
//  mem_out2   in   BLOCK_W    memory second block
//  busy       out  1          1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, wait counter 0, RR pointer favours data side.
//    Reset mid-operation aborts in-flight transaction: no strobe, no ready pulse after.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE (WAIT skipped when LATENCY=0).
//  - IDLE: if i_req|d_req, grant one, latch id/addr/we/wdata, go ISSUE.
//  - ISSUE (1 cycle): mem_rd=~we or mem_wr=we, never both; counter<=LATENCY.
//  - WAIT: decrement each cycle; at 1 go RESP.
//  - RESP (1 cycle): on read capture {mem_out1,mem_out2} into granted rdata;
//    pulse granted ready. Go IDLE.
//  - Timing: request sampled at edge N -> strobe cycle N+1 -> ready high cycle N+2+LATENCY.
//    Throughput one transaction per LATENCY+3 cycles.
//  - Requests sampled only in IDLE; req drop mid-transaction ignored (completes, pulses).
//    req still high in the ready cycle is re-sampled in IDLE as a new request.
//  - mem_wdata driven only for writes, else 0. Fetch side never writes.
//  - rdata of non-granted side unchanged; ready of non-granted side stays 0.
//  - Arbitration (default, fixed): d_req beats i_req on simultaneous request.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin; 1-bit pointer to last granted side; on simultaneous
//    requests the other side wins; single request always granted; pointer updates in IDLE.
//  ARB_RR_EN undefined: fixed priority, data over fetch; no pointer state.
// TESTING (LATENCY=2 unless noted)
//  1 d_req,d_we=0,d_addr=0x80 at edge N; mem_out1=A,mem_out2=B -> mem_rd high cycle N+1
//    only, mem_addr=0x80, d_ready pulse cycle N+4, d_rdata={A,B}, i_ready=0.
//  2 i_req and d_req both rise at N (fixed) -> data served first (d_ready N+4), fetch
//    sampled N+5, i_ready N+9; mem_rd,mem_wr never both 1.
//  3 ARB_RR_EN, i_req and d_req held high 4 transactions -> grant order d,i,d,i.
//  4 d_we=1,d_addr=0x100,d_wdata=128'hDEADBEEF_00000001_CAFEBABE_12345678 -> mem_wr one
//    cycle with that mem_wdata, d_ready N+4, d_rdata unchanged; following read returns it.
//  5 d read issued, rst_n low during WAIT -> outputs 0 immediately, no d_ready pulse; after
//    release busy=0 until next request.
//  6 LATENCY=0, i_req,i_addr=0x200 at N -> mem_rd cycle N+1, i_ready cycle N+2.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) sequencer for the shared block memory; ARB_RR_EN selects round-robin arbitration
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 i_ready,
  output logic [2*BLOCK_W-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [BLOCK_W-1:0]   d_wdata,
  output logic                 d_ready,
  output logic [2*BLOCK_W-1:0] d_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [BLOCK_W-1:0]   mem_wdata,
  input  logic [BLOCK_W-1:0]   mem_out1,
  input  logic [BLOCK_W-1:0]   mem_out2,
  output logic                 busy
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 gnt_d_q;   // 1 = data side owns the current transaction
  logic [ADDR_W-1:0]    addr_q;
  logic                 we_q;
  logic [BLOCK_W-1:0]   wdata_q;
  logic [2*BLOCK_W-1:0] i_rdata_q;
  logic [2*BLOCK_W-1:0] d_rdata_q;
  logic                 pick_d;
  logic                 any_req;
  logic                 enter_resp;

  assign any_req = i_req | d_req;

`ifdef ARB_RR_EN
  // Pointer holds the last granted side (1 = data); reset value 0 lets data win first.
  logic rr_last_q;

  // Round-robin pointer, advanced only when a grant is made in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      rr_last_q <= pick_d;
    end
  end

  assign pick_d = d_req & (~i_req | ~rr_last_q);
`else
  assign pick_d = d_req;
`endif

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: begin
        cnt_d   = CNT_W'(LATENCY);
        state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory data is sampled on the edge that enters RESP so rdata is valid alongside ready.
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // State, counter and transaction latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && any_req) begin
        gnt_d_q <= pick_d;
        addr_q  <= pick_d ? d_addr : i_addr;
        we_q    <= pick_d & d_we;
        wdata_q <= (pick_d & d_we) ? d_wdata : '0;
      end
      if (enter_resp && !we_q) begin
        if (gnt_d_q) d_rdata_q <= {mem_out1, mem_out2};
        else         i_rdata_q <= {mem_out1, mem_out2};
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = (state_q == S_ISSUE) & ~we_q;
  assign mem_wr    = (state_q == S_ISSUE) & we_q;
  assign mem_wdata = we_q ? wdata_q : '0;
  assign d_ready   = (state_q == S_RESP) & gnt_d_q;
  assign i_ready   = (state_q == S_RESP) & ~gnt_d_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (LATENCY=2 main instance, LATENCY=0 second instance)
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  localparam logic [127:0] WD = 128'hDEADBEEF_00000001_CAFEBABE_12345678;

  // main DUT signals
  logic         i_req = 0, d_req = 0, d_we = 0;
  logic [31:0]  i_addr = 0, d_addr = 0;
  logic [127:0] d_wdata = 0;
  logic         i_ready, d_ready, mem_rd, mem_wr, busy;
  logic [255:0] i_rdata, d_rdata;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_out1, mem_out2;

  // LATENCY=0 DUT signals
  logic         z_i_req = 0;
  logic [31:0]  z_i_addr = 0;
  logic         z_i_ready, z_d_ready, z_mem_rd, z_mem_wr, z_busy;
  logic [255:0] z_i_rdata, z_d_rdata;
  logic [31:0]  z_mem_addr;
  logic [127:0] z_mem_wdata, z_mem_out1, z_mem_out2;

  mem_arbiter #(.ADDR_W(32), .BLOCK_W(128), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_out1(mem_out1), .mem_out2(mem_out2), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .BLOCK_W(128), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ready(z_i_ready), .i_rdata(z_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(128'h0),
    .d_ready(z_d_ready), .d_rdata(z_d_rdata),
    .mem_addr(z_mem_addr), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_wdata(z_mem_wdata),
    .mem_out1(z_mem_out1), .mem_out2(z_mem_out2), .busy(z_busy)
  );

  // memory model: unwritten block at address a reads as a; one write slot
  logic         w_valid = 1'b0;
  logic [31:0]  w_addr = 0;
  logic [127:0] w_data = 0;

  function automatic logic [127:0] blk(input logic [31:0] a, input logic wv,
                                       input logic [31:0] wa, input logic [127:0] wd);
    return (wv && a == wa) ? wd : {96'h0, a};
  endfunction

  assign mem_out1   = blk(mem_addr, w_valid, w_addr, w_data);
  assign mem_out2   = blk(mem_addr + 32'h10, w_valid, w_addr, w_data);
  assign z_mem_out1 = blk(z_mem_addr, 1'b0, 32'h0, 128'h0);
  assign z_mem_out2 = blk(z_mem_addr + 32'h10, 1'b0, 32'h0, 128'h0);

  always @(posedge clk) begin
    if (mem_wr) begin
      w_valid <= 1'b1;
      w_addr  <= mem_addr;
      w_data  <= mem_wdata;
    end
  end

  // scoreboard queues
  typedef struct { bit side_d; int cyc; logic [255:0] rdata; } rsp_t;
  typedef struct { int cyc; bit wr; logic [31:0] addr; logic [127:0] wdata; } stb_t;
  rsp_t rsp_q[$];
  rsp_t zrsp_q[$];
  stb_t stb_q[$];

  task automatic exp_rsp(input bit side_d, input int c, input logic [255:0] r);
    rsp_t e;
    e.side_d = side_d; e.cyc = c; e.rdata = r;
    rsp_q.push_back(e);
  endtask

  task automatic exp_stb(input int c, input bit wr, input logic [31:0] a, input logic [127:0] wd);
    stb_t e;
    e.cyc = c; e.wr = wr; e.addr = a; e.wdata = wd;
    stb_q.push_back(e);
  endtask

  // response monitor (main DUT)
  rsp_t         m_e;
  logic [255:0] m_got;
  always @(negedge clk) begin
    if (i_ready || d_ready) begin
      total++;
      if (rsp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: cyc=%0d i_ready=%0b d_ready=%0b", cyc, i_ready, d_ready);
      end else begin
        m_e = rsp_q.pop_front();
        m_got = m_e.side_d ? d_rdata : i_rdata;
        if ((i_ready && d_ready) || d_ready != m_e.side_d || cyc != m_e.cyc || m_got != m_e.rdata) begin
          bad++;
          $display("FAIL rsp: got d_ready=%0b i_ready=%0b cyc=%0d rdata=%h, want side_d=%0b cyc=%0d rdata=%h",
                   d_ready, i_ready, cyc, m_got, m_e.side_d, m_e.cyc, m_e.rdata);
        end
      end
    end
  end

  // strobe monitor (main DUT)
  stb_t s_e;
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      total++;
      if (stb_q.size() == 0) begin
        bad++;
        $display("FAIL stb_unexpected: cyc=%0d rd=%0b wr=%0b addr=%h", cyc, mem_rd, mem_wr, mem_addr);
      end else begin
        s_e = stb_q.pop_front();
        if ((mem_rd && mem_wr) || mem_wr != s_e.wr || cyc != s_e.cyc ||
            mem_addr != s_e.addr || mem_wdata != s_e.wdata) begin
          bad++;
          $display("FAIL stb: got cyc=%0d rd=%0b wr=%0b addr=%h wdata=%h, want cyc=%0d wr=%0b addr=%h wdata=%h",
                   cyc, mem_rd, mem_wr, mem_addr, mem_wdata, s_e.cyc, s_e.wr, s_e.addr, s_e.wdata);
        end
      end
    end
  end

  // response monitor (LATENCY=0 DUT)
  rsp_t z_e;
  always @(negedge clk) begin
    if (z_i_ready || z_d_ready) begin
      total++;
      if (zrsp_q.size() == 0) begin
        bad++;
        $display("FAIL z_rsp_unexpected: cyc=%0d i_ready=%0b d_ready=%0b", cyc, z_i_ready, z_d_ready);
      end else begin
        z_e = zrsp_q.pop_front();
        if (z_d_ready || cyc != z_e.cyc || z_i_rdata != z_e.rdata) begin
          bad++;
          $display("FAIL z_rsp: got cyc=%0d d_ready=%0b rdata=%h, want cyc=%0d rdata=%h",
                   cyc, z_d_ready, z_i_rdata, z_e.cyc, z_e.rdata);
        end
      end
    end
  end

  task automatic wait_rsp(input bit side_d, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = side_d ? d_ready : i_ready;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout_ready: side_d=%0b not seen within %0d cycles", side_d, budget);
    end
  endtask

  int   k;
  bit   side;
  bit   ok;
  logic [31:0] a;

  initial begin
    repeat (3) @(negedge clk);

    // reset state of both instances
    total++;
    if (i_ready || d_ready || mem_rd || mem_wr || busy || mem_addr != 0 || mem_wdata != 0 ||
        i_rdata != 0 || d_rdata != 0 || z_i_ready || z_mem_rd || z_busy) begin
      bad++;
      $display("FAIL reset_state: busy=%0b rd=%0b wr=%0b addr=%h z_busy=%0b, want all 0",
               busy, mem_rd, mem_wr, mem_addr, z_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single data read at 0x80
    k = cyc;
    exp_stb(k + 1, 1'b0, 32'h80, 128'h0);
    exp_rsp(1'b1, k + 4, {128'h80, 128'h90});
    d_we = 0; d_addr = 32'h80; d_req = 1;
    wait_rsp(1'b1, 20);
    d_req = 0;
    @(negedge clk);

    // 2: simultaneous requests, data first then fetch
    k = cyc;
    exp_stb(k + 1, 1'b0, 32'h40, 128'h0);
    exp_rsp(1'b1, k + 4, {128'h40, 128'h50});
    exp_stb(k + 6, 1'b0, 32'h300, 128'h0);
    exp_rsp(1'b0, k + 9, {128'h300, 128'h310});
    d_addr = 32'h40; i_addr = 32'h300; d_req = 1; i_req = 1;
    wait_rsp(1'b1, 20);
    d_req = 0;
    wait_rsp(1'b0, 20);
    i_req = 0;
    @(negedge clk);

    // 3: both held for four transactions
    k = cyc;
    d_addr = 32'h500; i_addr = 32'h600;
    for (int j = 0; j < 4; j++) begin
      side = RR_MODE ? (j % 2 == 0) : 1'b1;
      a = side ? 32'h500 : 32'h600;
      exp_stb(k + 1 + 5 * j, 1'b0, a, 128'h0);
      exp_rsp(side, k + 4 + 5 * j, {96'h0, a, 96'h0, a + 32'h10});
    end
    d_req = 1; i_req = 1;
    for (int j = 0; j < 4; j++) begin
      wait_rsp(RR_MODE ? (j % 2 == 0) : 1'b1, 20);
    end
    d_req = 0; i_req = 0;
    @(negedge clk);

    // 4: write, d_rdata holds the last data read
    k = cyc;
    exp_stb(k + 1, 1'b1, 32'h100, WD);
    exp_rsp(1'b1, k + 4, {128'h500, 128'h510});
    d_we = 1; d_addr = 32'h100; d_wdata = WD; d_req = 1;
    wait_rsp(1'b1, 20);
    d_req = 0; d_we = 0; d_wdata = 0;
    @(negedge clk);
    total++;
    if (i_rdata != (RR_MODE ? {128'h600, 128'h610} : {128'h300, 128'h310})) begin
      bad++;
      $display("FAIL i_rdata_held: got %h", i_rdata);
    end

    // 4b: read back the written block
    k = cyc;
    exp_stb(k + 1, 1'b0, 32'h100, 128'h0);
    exp_rsp(1'b1, k + 4, {WD, 128'h110});
    d_addr = 32'h100; d_req = 1;
    wait_rsp(1'b1, 20);
    d_req = 0;
    @(negedge clk);

    // 5: reset asserted during WAIT aborts the read
    k = cyc;
    exp_stb(k + 1, 1'b0, 32'h700, 128'h0);
    d_addr = 32'h700; d_req = 1;
    @(negedge clk);
    @(negedge clk);
    d_req = 0;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_rd || mem_wr || busy || d_ready || i_ready || mem_addr != 0 || mem_wdata != 0 ||
        d_rdata != 0 || i_rdata != 0) begin
      bad++;
      $display("FAIL reset_abort: busy=%0b rd=%0b addr=%h d_rdata=%h, want all 0", busy, mem_rd, mem_addr, d_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (busy) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_after_reset: busy seen 1, want 0");
    end

    // 6: LATENCY=0 instance, fetch at 0x200
    k = cyc;
    begin
      rsp_t e;
      e.side_d = 1'b0; e.cyc = k + 2; e.rdata = {128'h200, 128'h210};
      zrsp_q.push_back(e);
    end
    z_i_addr = 32'h200; z_i_req = 1;
    @(negedge clk);
    total++;
    if (!z_mem_rd || z_mem_wr || z_mem_addr != 32'h200) begin
      bad++;
      $display("FAIL z_strobe: rd=%0b wr=%0b addr=%h, want rd=1 wr=0 addr=00000200", z_mem_rd, z_mem_wr, z_mem_addr);
    end
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      if (n > 0) @(negedge clk);
      if (z_i_ready) ok = 1'b1;
      else if (n == 0) @(negedge clk);
      if (z_i_ready) ok = 1'b1;
    end
    z_i_req = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL z_timeout: i_ready not seen");
    end

    repeat (6) @(negedge clk);
    total++;
    if (rsp_q.size() != 0 || stb_q.size() != 0 || zrsp_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained: rsp=%0d stb=%0d z=%0d left, want 0",
               rsp_q.size(), stb_q.size(), zrsp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
